// File: rtl/instr_sequencer_pkg.sv
// Shared instruction-set constants: processor ALU opcodes plus the sequencer's
// reserved control-flow opcodes and the NOP word.
package instr_sequencer_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_OUT  = 8'h0E;

    // Control-flow opcodes are resolved inside the sequencer and never reach the processor.
    localparam logic [7:0] OP_JMP  = 8'hF0;
    localparam logic [7:0] OP_JZ   = 8'hF1;
    localparam logic [7:0] OP_JC   = 8'hF2;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [31:0] NOP_WORD = {OP_NOP, 24'h0};

    function automatic logic [31:0] mk_word(input logic [7:0] op, input logic [7:0] rd,
                                            input logic [7:0] rs1, input logic [7:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// Program store: synchronous write port for loading, asynchronous read port for fetch.
module instr_prog_mem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset; program contents survive rst and clearing it would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue unit: walks program memory, resolves JMP/JZ/JC/HALT locally and
// forwards every other word to the processor one cycle after fetch.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int MAX_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              start,
    input  logic              zf,
    input  logic              cf,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_BR_WAIT = 2'd2;

    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [31:0]       word;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              wdog_expire;
    logic              branch_taken;
    logic              unused_word_bits;

    instr_prog_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (word)
    );

    assign busy             = (state != ST_IDLE);
    assign opcode           = word[31:24];
    assign target           = word[ADDR_W-1:0];
    assign pc_inc           = pc + ADDR_W'(1);
    assign wdog_expire      = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    assign unused_word_bits = ^word[23:ADDR_W];

    // Memory is frozen while busy, so in BR_WAIT the word at pc is still the branch.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        branch_taken = 1'b0;
        if (opcode == OP_JZ) begin
            branch_taken = zf;
        end else if (opcode == OP_JC) begin
            branch_taken = cf;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instruction <= NOP_WORD;
            pc          <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    instruction <= NOP_WORD;
                    if (start) begin
                        pc        <= '0;
                        cycle_cnt <= '0;
                        timeout   <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (wdog_expire) begin
                        timeout     <= 1'b1;
                        instruction <= NOP_WORD;
                        state       <= ST_IDLE;
                    end else begin
                        case (opcode)
                            OP_JMP: begin
                                instruction <= NOP_WORD;
                                pc          <= target;
                            end
                            OP_JZ, OP_JC: begin
                                instruction <= NOP_WORD;
                                state       <= ST_BR_WAIT;
                            end
                            OP_HALT: begin
                                instruction <= NOP_WORD;
                                done        <= 1'b1;
                                state       <= ST_IDLE;
                            end
                            default: begin
                                instruction <= word;
                                pc          <= pc_inc;
                            end
                        endcase
                    end
                end
                ST_BR_WAIT: begin
                    cycle_cnt   <= cycle_cnt + CNT_W'(1);
                    instruction <= NOP_WORD;
                    if (wdog_expire) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        pc    <= branch_taken ? target : pc_inc;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    instruction <= NOP_WORD;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
